// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its RAM.
// Optional byte-write support is enabled with DMEM_BYTE_WRITE_EN.
package dmem_pkg;

  localparam int WORD_W    = 32;
  localparam int BE_W      = 4;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bytes with a set mask bit come from new_w, the rest keep old_w.
  function automatic logic [WORD_W-1:0] merge_word(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [BE_W-1:0]   mask
  );
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM; read data registers on every enabled access.
// With DMEM_BYTE_WRITE_EN defined, stores honour the per-byte mask.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   mask,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] merged;

`ifdef DMEM_BYTE_WRITE_EN
  assign merged = merge_word(mem[addr], wdata, mask);
`else
  logic unused_mask;
  assign unused_mask = ^mask;
  assign merged      = wdata;
`endif

  // Storage itself is never reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= merged;
  end

  // A store returns the word as written, a load returns the stored word;
  // the value is held until the next access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? merged : mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY
// cycles, accesses dmem_array, then pulses resp_valid. Byte writes: DMEM_BYTE_WRITE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wmem,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic [TAG_W-1:0]  resp_tag,
  output state_t            dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; req_ready is 1 only in IDLE. resp_valid is a
  // single-cycle pulse with no back-pressure; rdata/tag stay until the next access.

  localparam logic [LAT_CNT_W-1:0] LAT = LAT_CNT_W'(LATENCY);

  state_t                 state, state_nxt;
  logic [LAT_CNT_W-1:0]   cnt, cnt_nxt;
  logic                   commit;

  logic                   lat_wmem;
  logic [ADDR_W-1:0]      lat_addr;
  logic [WORD_W-1:0]      lat_wdata;
  logic [BE_W-1:0]        lat_be;
  logic [TAG_W-1:0]       lat_tag;

  logic                   acc_wmem;
  logic [ADDR_W-1:0]      acc_addr;
  logic [WORD_W-1:0]      acc_wdata;
  logic [BE_W-1:0]        acc_be;
  logic [TAG_W-1:0]       acc_tag;
  logic [BE_W-1:0]        acc_mask;
  logic                   mem_en;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_wmem  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_tag   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (req_valid && req_ready) begin
        lat_wmem  <= req_wmem;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        lat_tag   <= req_tag;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    commit     = 1'b0;
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          cnt_nxt = LAT;
          if (LATENCY == 0) begin
            commit    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 1'b1;
        if (cnt == LAT_CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A zero-latency access happens on the accept edge, before the latches load.
  always_comb begin
    if (state == IDLE) begin
      acc_wmem  = req_wmem;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
      acc_tag   = req_tag;
    end else begin
      acc_wmem  = lat_wmem;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
      acc_tag   = lat_tag;
    end
  end

`ifdef DMEM_BYTE_WRITE_EN
  assign acc_mask = acc_be;
`else
  logic unused_be;
  assign unused_be = ^acc_be;
  assign acc_mask  = '1;
`endif

  // Reset on the commit edge suppresses the write.
  assign mem_en = commit && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_tag <= '0;
    end else if (commit) begin
      resp_tag <= acc_tag;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en),
    .we    (acc_wmem),
    .addr  (acc_addr),
    .wdata (acc_wdata),
    .mask  (acc_mask),
    .rdata (resp_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances, directed
// vector table, reset corner sequences and randomized traffic vs a memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared request drive ----------------
  logic        req_valid;
  logic        req_wmem;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [3:0]  req_tag;
  logic        use0;

  logic        vreq2, vreq0;
  assign vreq2 = req_valid & ~use0;
  assign vreq0 = req_valid & use0;

  logic        ready2, stall2, rv2, ready0, stall0, rv0;
  logic [31:0] rd2, rd0;
  logic [3:0]  tag2, tag0;
  state_t      st2, st0;

  dmem_responder #(.ADDR_W(8), .LATENCY(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(vreq2), .req_wmem(req_wmem),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_tag(req_tag),
    .req_ready(ready2), .stall(stall2), .resp_valid(rv2), .resp_rdata(rd2),
    .resp_tag(tag2), .dbg_state(st2)
  );

  dmem_responder #(.ADDR_W(8), .LATENCY(0), .TAG_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(vreq0), .req_wmem(req_wmem),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_tag(req_tag),
    .req_ready(ready0), .stall(stall0), .resp_valid(rv0), .resp_rdata(rd0),
    .resp_tag(tag0), .dbg_state(st0)
  );

  logic        o_ready, o_stall, o_rv;
  logic [31:0] o_rd;
  logic [3:0]  o_tag;
  assign o_ready = use0 ? ready0 : ready2;
  assign o_stall = use0 ? stall0 : stall2;
  assign o_rv    = use0 ? rv0    : rv2;
  assign o_rd    = use0 ? rd0    : rd2;
  assign o_tag   = use0 ? tag0   : tag2;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [2][256];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Reference: a word array per instance, byte lanes merged arithmetically.
  function automatic logic [31:0] model_access(input int d, input logic wmem,
      input logic [7:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (wmem) begin
`ifdef DMEM_BYTE_WRITE_EN
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[d][a][8*b +: 8] = wd[8*b +: 8];
      end
`else
      mem_m[d][a] = wd;
`endif
    end
    return mem_m[d][a];
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input logic wmem, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [3:0] tag, input bit hold);
    int lat, n, stall_n;
    logic [31:0] exp_d;
    lat = use0 ? 0 : 2;
    exp_d = exp_q.pop_front();
    @(negedge clk);
    req_wmem = wmem; req_addr = addr; req_wdata = wdata; req_be = be; req_tag = tag;
    req_valid = 1'b1;
    #1;
    check("ready_idle", o_ready, 1);
    n = 0;
    stall_n = 0;
    while (!o_rv && n < 40) begin
      if (o_stall) stall_n++;
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      #1;
      n++;
    end
    check("latency", n, lat + 1);
    check("stall_cycles", stall_n, lat + 1);
    check("resp_valid", o_rv, 1);
    check("resp_rdata", o_rd, exp_d);
    check("resp_tag", o_tag, tag);
    check("ready_in_resp", o_ready, 0);
    check("stall_in_resp", o_stall, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("single_pulse", o_rv, 0);
    check("ready_after", o_ready, 1);
    check("rdata_held", o_rd, exp_d);
    check("tag_held", o_tag, tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          lat0;
    bit          wmem;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  tag;
    bit          hold;
    logic [31:0] exp_rdata;
  } vec_t;

`ifdef DMEM_BYTE_WRITE_EN
  localparam logic [31:0] BYTE_EXP = 32'h11BB33DD;
`else
  localparam logic [31:0] BYTE_EXP = 32'hAABBCCDD;
`endif

  vec_t vecs[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool[8];
    logic [7:0] a;
    logic [31:0] w;
    logic [3:0] be, tg;
    logic wm;
    bit saw;

    vecs[0]  = '{0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 4'h3, 0, 32'hDEADBEEF};
    vecs[1]  = '{0, 0, 8'h10, 32'h0,        4'hF, 4'h4, 0, 32'hDEADBEEF};
    vecs[2]  = '{1, 1, 8'hFF, 32'h12345678, 4'hF, 4'h1, 0, 32'h12345678};
    vecs[3]  = '{1, 0, 8'hFF, 32'h0,        4'hF, 4'h2, 0, 32'h12345678};
    vecs[4]  = '{0, 1, 8'h20, 32'h00000001, 4'hF, 4'h5, 0, 32'h00000001};
    vecs[5]  = '{0, 1, 8'h40, 32'h00000005, 4'hF, 4'h6, 0, 32'h00000005};
    vecs[6]  = '{0, 1, 8'h30, 32'h11223344, 4'hF, 4'h7, 0, 32'h11223344};
    vecs[7]  = '{0, 1, 8'h30, 32'hAABBCCDD, 4'b0101, 4'h8, 0, BYTE_EXP};
    vecs[8]  = '{0, 0, 8'h30, 32'h0,        4'hF, 4'h9, 1, BYTE_EXP};
    vecs[9]  = '{0, 1, 8'hFF, 32'hCAFEF00D, 4'hF, 4'hA, 0, 32'hCAFEF00D};
    vecs[10] = '{0, 0, 8'hFF, 32'h0,        4'hF, 4'hB, 0, 32'hCAFEF00D};
    vecs[11] = '{1, 0, 8'hFF, 32'h0,        4'hF, 4'hC, 1, 32'h12345678};

    rst = 1'b1; use0 = 1'b0; req_valid = 1'b0; req_wmem = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_resp_valid", rv2, 0);
    check("rst_resp_rdata", rd2, 0);
    check("rst_resp_tag", tag2, 0);
    check("rst_req_ready", ready2, 1);
    check("rst_stall", stall2, 0);
    check("rst_state", st2, IDLE);
    check("rst0_resp_valid", rv0, 0);
    check("rst0_state", st0, IDLE);

    for (int i = 0; i < 12; i++) begin
      use0 = vecs[i].lat0;
      exp_q.push_back(vecs[i].exp_rdata);
      run_txn(vecs[i].wmem, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].tag, vecs[i].hold);
    end
    use0 = 1'b0;

    // Reset while waiting: store to 0x20 must be abandoned.
    @(negedge clk);
    req_wmem = 1'b1; req_addr = 8'h20; req_wdata = 32'hAAAA5555; req_be = 4'hF; req_tag = 4'hD;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_state", st2, IDLE);
    check("abort_rdata_cleared", rd2, 0);
    saw = 0;
    repeat (4) begin
      @(negedge clk);
      if (rv2) saw = 1;
    end
    check("abort_no_resp", saw, 0);
    exp_q.push_back(32'h00000001);
    run_txn(1'b0, 8'h20, 32'h0, 4'hF, 4'h1, 0);

    // Reset on the commit edge: store to 0x40 must not land.
    @(negedge clk);
    req_wmem = 1'b1; req_addr = 8'h40; req_wdata = 32'hBADBAD00; req_be = 4'hF; req_tag = 4'hE;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("commit_rst_no_resp", rv2, 0);
    exp_q.push_back(32'h00000005);
    run_txn(1'b0, 8'h40, 32'h0, 4'hF, 4'h2, 0);

    // Randomized traffic on both instances against the reference model.
    for (int p = 0; p < 8; p++) pool[p] = 8'h80 + 8'(p * 5);
    for (int d = 0; d < 2; d++) begin
      use0 = (d == 1);
      for (int p = 0; p < 8; p++) begin
        w = $urandom;
        tg = 4'($urandom_range(0, 15));
        exp_q.push_back(model_access(d, 1'b1, pool[p], w, 4'hF));
        run_txn(1'b1, pool[p], w, 4'hF, tg, 0);
      end
      for (int k = 0; k < 25; k++) begin
        wm = 1'($urandom_range(0, 1));
        a  = pool[$urandom_range(0, 7)];
        w  = $urandom;
        be = 4'($urandom_range(0, 15));
        tg = 4'($urandom_range(0, 15));
        exp_q.push_back(model_access(d, wm, a, w, be));
        run_txn(wm, a, w, be, tg, ($urandom_range(0, 3) == 0));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    use0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
